sdram_req_sched: RTL and testbench

Request scheduler between the SDRAM test/traffic FSM and the NESTang `sdram` controller. It accepts byte read/write requests over a valid/ready handshake and buffers one request. It converts each request into the controller's single-cycle `rd`/`wr` pulses and generates periodic auto-refresh, so clients never track refresh timing. Read data returns as a one-cycle response pulse.

---
 rtl/sdram_sched_pkg.sv | 20 ++
 rtl/sdram_refresh_timer.sv | 57 +++++
 rtl/sdram_req_sched.sv | 149 ++++++++++++++
 tb/tb_sdram_req_sched.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_sched_pkg.sv
// rtl/sdram_sched_pkg.sv - shared types and constants for the SDRAM request scheduler
package sdram_sched_pkg;

  localparam int ADDR_W = 23;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CMD      = 3'd1,
    S_CMD_WAIT = 3'd2,
    S_REF      = 3'd3,
    S_REF_WAIT = 3'd4
  } sched_state_t;

  // Clock cycles between auto-refresh commands.
  function automatic int refresh_count(input int freq, input int us);
    return (freq / 1_000_000) * us;
  endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// rtl/sdram_refresh_timer.sv - refresh interval timer with owed-refresh debt and overrun flag
module sdram_refresh_timer
  import sdram_sched_pkg::*;
#(
  parameter int FREQ       = 27_000_000,
  parameter int REFRESH_US = 15,
  parameter int MAX_DEBT   = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic ref_issued,
  output logic ref_owed,
  output logic ref_overrun
);

  localparam int RC = refresh_count(FREQ, REFRESH_US);
  localparam int TW = (RC > 1) ? $clog2(RC) : 1;
  localparam int DW = $clog2(MAX_DEBT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(RC - 1);
  localparam logic [DW-1:0] DEBT_MAX   = DW'(MAX_DEBT);

  logic [TW-1:0] r_timer;
  logic [DW-1:0] r_debt;
  logic          r_overrun;
  logic          w_wrap;

  assign w_wrap      = (r_timer == TIMER_LAST);
  assign ref_owed    = (r_debt != '0);
  assign ref_overrun = r_overrun;

  // Free-running interval counter, 0..RC-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer <= '0;
    end else begin
      r_timer <= w_wrap ? '0 : r_timer + TW'(1);
    end
  end

  // Debt grows on each wrap and shrinks on each issued refresh; a wrap with
  // a full debt is an overrun that sticks until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_debt    <= '0;
      r_overrun <= 1'b0;
    end else if (w_wrap && !ref_issued) begin
      if (r_debt == DEBT_MAX) begin
        r_overrun <= 1'b1;
      end else begin
        r_debt <= r_debt + DW'(1);
      end
    end else if (!w_wrap && ref_issued && (r_debt != '0)) begin
      r_debt <= r_debt - DW'(1);
    end
  end

endmodule

// File: rtl/sdram_req_sched.sv
// rtl/sdram_req_sched.sv - one-entry request buffer and command/refresh scheduler for the sdram controller
module sdram_req_sched
  import sdram_sched_pkg::*;
#(
  parameter int FREQ       = 27_000_000,
  parameter int REFRESH_US = 15,
  parameter int MAX_DEBT   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_din,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              rd,
  output logic              wr,
  output logic              refresh,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] dout,
  input  logic              data_ready,
  input  logic              busy,
  output logic              ref_overrun
);

  sched_state_t      r_state;
  sched_state_t      w_state_next;
  logic              r_first;
  logic              r_pending;
  logic              r_pend_wr;
  logic [ADDR_W-1:0] r_pend_addr;
  logic [DATA_W-1:0] r_pend_din;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_din;
  logic              r_cur_rd;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_resp_data;
  logic              w_ref_owed;
  logic              w_ref_issued;
  logic              w_load_cmd;

  assign w_ref_issued = (r_state == S_REF);
  assign w_load_cmd   = (r_state == S_IDLE) && (w_state_next == S_CMD);

  assign req_ready  = !r_pending;
  assign rd         = (r_state == S_CMD) && !r_pend_wr;
  assign wr         = (r_state == S_CMD) && r_pend_wr;
  assign refresh    = w_ref_issued;
  assign addr       = r_addr;
  assign din        = r_din;
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;

  sdram_refresh_timer #(
    .FREQ       (FREQ),
    .REFRESH_US (REFRESH_US),
    .MAX_DEBT   (MAX_DEBT)
  ) u_refresh_timer (
    .clk         (clk),
    .reset       (reset),
    .ref_issued  (w_ref_issued),
    .ref_owed    (w_ref_owed),
    .ref_overrun (ref_overrun)
  );

  // Next state: refresh wins over a pending request; the first wait cycle
  // ignores busy because the controller raises it one cycle after a pulse.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (!busy) begin
          if (w_ref_owed) begin
            w_state_next = S_REF;
          end else if (r_pending) begin
            w_state_next = S_CMD;
          end
        end
      end
      S_CMD:   w_state_next = S_CMD_WAIT;
      S_REF:   w_state_next = S_REF_WAIT;
      S_CMD_WAIT, S_REF_WAIT: begin
        if (!r_first && !busy) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register and the busy-mask flag for the first wait cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_first <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_first <= (r_state == S_CMD) || (r_state == S_REF);
    end
  end

  // One-entry request buffer; it frees up as the command pulse goes out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending   <= 1'b0;
      r_pend_wr   <= 1'b0;
      r_pend_addr <= '0;
      r_pend_din  <= '0;
    end else if (r_state == S_CMD) begin
      r_pending <= 1'b0;
    end else if (req_valid && !r_pending) begin
      r_pending   <= 1'b1;
      r_pend_wr   <= req_wr;
      r_pend_addr <= req_addr;
      r_pend_din  <= req_din;
    end
  end

  // Controller operands are loaded just before the pulse and then held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr   <= '0;
      r_din    <= '0;
      r_cur_rd <= 1'b0;
    end else if (w_load_cmd) begin
      r_addr   <= r_pend_addr;
      r_din    <= r_pend_din;
      r_cur_rd <= !r_pend_wr;
    end
  end

  // Capture read data only while waiting on our own read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      if ((r_state == S_CMD_WAIT) && r_cur_rd && data_ready) begin
        r_resp_valid <= 1'b1;
        r_resp_data  <= dout;
      end
    end
  end

endmodule

// File: tb/tb_sdram_req_sched.sv
// tb/tb_sdram_req_sched.sv - self-checking bench for sdram_req_sched
module tb_sdram_req_sched;

  localparam int K_REF = 0;
  localparam int K_RD  = 1;
  localparam int K_WR  = 2;

  typedef struct packed {
    logic        w;
    logic [22:0] a;
    logic [7:0]  d;
  } req_t;

  typedef struct packed {
    int          kind;
    int          c;
    logic [22:0] a;
  } pulse_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [22:0] req_addr = '0;
  logic [7:0]  req_din = '0;
  logic        resp_valid;
  logic [7:0]  resp_data;
  logic        rd, wr, refresh;
  logic [22:0] addr;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        data_ready;
  logic        busy;
  logic        ref_overrun;

  logic        force_busy = 1'b0;
  logic        spur_dr = 1'b0;
  logic        real_dr;

  int n_checks = 0;
  int n_errors = 0;

  int     cyc = 0;
  int     last_pulse = -100;
  int     last_acc = -1;
  int     n_resp = 0;
  bit     got_acc = 0;
  logic   prev_real_dr = 1'b0;
  req_t   exp_cmd[$];
  logic [7:0] exp_resp[$];
  pulse_t plog[$];
  int     rc[$];
  logic [7:0] ref_mem [0:255];

  sdram_req_sched #(
    .FREQ       (1_000_000),
    .REFRESH_US (15),
    .MAX_DEBT   (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_wr      (req_wr),
    .req_addr    (req_addr),
    .req_din     (req_din),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .rd          (rd),
    .wr          (wr),
    .refresh     (refresh),
    .addr        (addr),
    .din         (din),
    .dout        (dout),
    .data_ready  (data_ready),
    .busy        (busy),
    .ref_overrun (ref_overrun)
  );

  always #5 clk = ~clk;

  // Controller model: busy for 4 cycles starting 1 cycle after a pulse,
  // read data on the last busy cycle.
  logic [2:0] m_ctr;
  logic       m_rd;
  logic [7:0] m_dout;
  logic [7:0] ctl_mem [0:255];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ctr  <= '0;
      m_rd   <= 1'b0;
      m_dout <= '0;
      for (int i = 0; i < 256; i++) ctl_mem[i] <= 8'h00;
    end else if (rd || wr || refresh) begin
      m_ctr <= 3'd4;
      m_rd  <= rd;
      if (wr) ctl_mem[addr[7:0]] <= din;
      if (rd) m_dout <= ctl_mem[addr[7:0]];
    end else if (m_ctr != 3'd0) begin
      m_ctr <= m_ctr - 3'd1;
    end
  end

  assign busy       = (m_ctr != 3'd0) || force_busy;
  assign real_dr    = (m_ctr == 3'd1) && m_rd;
  assign data_ready = real_dr || spur_dr;
  assign dout       = m_dout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int count_kind(input int k);
    int n = 0;
    foreach (plog[i]) if (plog[i].kind == k) n++;
    return n;
  endfunction

  task automatic observe(input bit acc);
    pulse_t p;
    req_t   e;
    if (rd || wr || refresh) begin
      chk("pulse_onehot", 32'(rd) + 32'(wr) + 32'(refresh), 1);
      chk("pulse_gap", 32'((cyc - last_pulse) >= 2), 1);
      last_pulse = cyc;
      p.kind = refresh ? K_REF : (wr ? K_WR : K_RD);
      p.c    = cyc;
      p.a    = addr;
      plog.push_back(p);
    end
    if (rd || wr) begin
      chk("cmd_expected", 32'(exp_cmd.size() > 0), 1);
      if (exp_cmd.size() > 0) begin
        e = exp_cmd.pop_front();
        chk("cmd_kind", 32'(wr), 32'(e.w));
        chk("cmd_addr", 32'(addr), 32'(e.a));
        if (e.w) chk("cmd_din", 32'(din), 32'(e.d));
      end
    end
    chk("resp_timing", 32'(resp_valid), 32'(prev_real_dr));
    if (resp_valid) begin
      n_resp++;
      chk("resp_expected", 32'(exp_resp.size() > 0), 1);
      if (exp_resp.size() > 0) chk("resp_data", 32'(resp_data), 32'(exp_resp.pop_front()));
    end
    if (acc) chk("ready_low_full", 32'(req_ready), 0);
    prev_real_dr = real_dr;
  endtask

  task automatic tick();
    bit   acc;
    req_t e;
    acc = req_valid && req_ready;
    got_acc = acc;
    if (acc) begin
      e.w = req_wr;
      e.a = req_addr;
      e.d = req_din;
      exp_cmd.push_back(e);
      if (req_wr) ref_mem[req_addr[7:0]] = req_din;
      else exp_resp.push_back(ref_mem[req_addr[7:0]]);
      last_acc = cyc;
    end
    @(negedge clk);
    cyc++;
    observe(acc);
  endtask

  task automatic send(input logic w, input logic [22:0] a, input logic [7:0] d, input int maxw);
    int k = 0;
    req_valid = 1'b1;
    req_wr    = w;
    req_addr  = a;
    req_din   = d;
    got_acc   = 0;
    while (!got_acc && k < maxw) begin
      tick();
      k++;
    end
    req_valid = 1'b0;
    chk("send_accept", 32'(got_acc), 1);
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_cmd.size() + exp_resp.size()) != 0 && k < 400) begin
      tick();
      k++;
    end
    repeat (8) tick();
    chk("drain_empty", exp_cmd.size() + exp_resp.size(), 0);
  endtask

  // Called just after a negedge; checks the asynchronous reset values.
  task automatic do_reset();
    reset     = 1'b1;
    req_valid = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_pulses", 32'(rd) + 32'(wr) + 32'(refresh), 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_din", 32'(din), 0);
    chk("rst_resp_data", 32'(resp_data), 0);
    chk("rst_overrun", 32'(ref_overrun), 0);
    repeat (2) @(negedge clk);
    exp_cmd.delete();
    exp_resp.delete();
    plog.delete();
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    reset        = 1'b0;
    cyc          = 0;
    last_pulse   = -100;
    prev_real_dr = 1'b0;
  endtask

  initial begin
    int nb;
    int wr_cyc;
    int t_acc;

    @(negedge clk);
    do_reset();

    // Idle after reset, with one stray data_ready that must be ignored.
    repeat (5) tick();
    spur_dr = 1'b1;
    tick();
    spur_dr = 1'b0;
    while (cyc < 40) tick();
    rc.delete();
    foreach (plog[i]) if (plog[i].kind == K_REF) rc.push_back(plog[i].c);
    chk("idle_ref_count", rc.size(), 2);
    if (rc.size() == 2) begin
      chk("idle_ref1_window", 32'(rc[0] >= 14 && rc[0] <= 18), 1);
      chk("idle_ref2_window", 32'(rc[1] >= 29 && rc[1] <= 33), 1);
    end
    chk("idle_overrun", 32'(ref_overrun), 0);
    chk("stray_dr_ignored", 32'(resp_data), 0);

    // Write 0x3E to address 0, then read it back.
    plog.delete();
    n_resp = 0;
    send(1'b1, 23'd0, 8'h3E, 20);
    t_acc = last_acc;
    send(1'b0, 23'd0, 8'h00, 60);
    drain();
    chk("wr_rd_wr_count", count_kind(K_WR), 1);
    chk("wr_rd_rd_count", count_kind(K_RD), 1);
    chk("wr_rd_resp_count", n_resp, 1);
    chk("wr_rd_resp_data", 32'(resp_data), 32'h3E);
    wr_cyc = -1;
    foreach (plog[i]) if (plog[i].kind == K_WR && wr_cyc < 0) wr_cyc = plog[i].c;
    chk("wr_latency", wr_cyc, t_acc + 2);

    // Three writes with req_valid held high throughout.
    plog.delete();
    nb        = 0;
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_addr  = 23'd1;
    req_din   = 8'hA0;
    for (int k = 0; k < 200 && nb < 3; k++) begin
      tick();
      if (got_acc) begin
        nb++;
        req_addr = 23'(nb + 1);
        req_din  = 8'(8'hA0 + nb);
      end
    end
    req_valid = 1'b0;
    chk("b2b_accepts", nb, 3);
    drain();
    chk("b2b_wr_count", count_kind(K_WR), 3);

    // Randomized traffic against the scoreboard and memory model.
    plog.delete();
    n_resp = 0;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 4)) tick();
      send(1'($urandom_range(0, 1)), 23'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 100);
    end
    drain();
    chk("rand_overrun", 32'(ref_overrun), 0);
    chk("rand_cmds", count_kind(K_RD) + count_kind(K_WR), 40);

    // Request handshake in the same cycle the timer wraps.
    @(negedge clk);
    do_reset();
    repeat (14) tick();
    send(1'b1, 23'd5, 8'h77, 5);
    chk("wrap_acc_cycle", last_acc, 14);
    drain();
    chk("wrap_pulses", 32'(plog.size() >= 2), 1);
    if (plog.size() >= 2) begin
      chk("wrap_first_is_ref", plog[0].kind, K_REF);
      chk("wrap_then_wr", plog[1].kind, K_WR);
    end

    // Controller busy for 50 cycles from reset: debt saturates, overrun.
    force_busy = 1'b1;
    @(negedge clk);
    do_reset();
    while (cyc < 44) tick();
    chk("overrun_before_3rd_wrap", 32'(ref_overrun), 0);
    tick();
    chk("overrun_after_3rd_wrap", 32'(ref_overrun), 1);
    while (cyc < 50) tick();
    chk("busy_no_pulse", plog.size(), 0);
    force_busy = 1'b0;
    while (cyc < 62) tick();
    chk("busy_ref_after", count_kind(K_REF), 2);
    chk("overrun_sticky", 32'(ref_overrun), 1);

    // Reset while a write is in flight and a read is pending.
    @(negedge clk);
    do_reset();
    send(1'b1, 23'd9, 8'h55, 5);
    while (cyc < 3) tick();
    send(1'b0, 23'd9, 8'h00, 5);
    chk("mid_pending", 32'(req_ready), 0);
    chk("mid_wr_issued", count_kind(K_WR), 1);
    do_reset();
    repeat (12) tick();
    chk("post_reset_no_pulse", plog.size(), 0);
    n_resp = 0;
    send(1'b0, 23'd9, 8'h00, 5);
    drain();
    chk("post_reset_read", n_resp, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
